sc_dot_product_engine: RTL and testbench

Self-contained stochastic-computing dot-product engine: binary operand vectors in, binary dot-product estimate out. It contains the full chain: two LFSR noise sources, per-channel SNGs, a per-channel multiplier, a counter-driven mux scaled adder and a stream-to-count accumulator. A start/busy/done handshake wraps the chain. It supports both unipolar and bipolar encodings and a parametrised stream length. It replaces hand-wired LFSR/SNG/adder/converter chains at integration level.

---
 rtl/sc_dot_product_engine.sv | 146 ++++++++++++++
 tb/tb_sc_dot_product_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_dot_product_engine.sv
// Stochastic-computing dot-product engine.
// Two LFSRs feed per-channel SNGs, a multiplier and a mux adder into a counter.
module sc_dot_product_engine #(
  parameter int DIMENSION = 4,
  parameter int WIDTH = 8,
  parameter int LEN_LOG2 = 8,
  parameter logic [WIDTH-1:0] SEED_DATA = 'hC3,
  parameter logic [WIDTH-1:0] SEED_WEIGHT = 'h81
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mode,
  input  logic [WIDTH*DIMENSION-1:0] data,
  input  logic [WIDTH*DIMENSION-1:0] weights,
  output logic busy,
  output logic done,
  output logic [LEN_LOG2:0] count,
  output logic [2*WIDTH+$clog2(DIMENSION):0] dot
);

  localparam int SEL_W = $clog2(DIMENSION);
  localparam int N = 1 << LEN_LOG2;
  localparam int CW = LEN_LOG2 + 1;
  localparam int DW = 2*WIDTH + SEL_W + 1;
  localparam int SHIFT = 2*WIDTH + SEL_W - LEN_LOG2;

  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      4:  return 16'h000C;
      5:  return 16'h0014;
      6:  return 16'h0030;
      7:  return 16'h0060;
      8:  return 16'h00B8;
      9:  return 16'h0110;
      10: return 16'h0240;
      11: return 16'h0500;
      12: return 16'h0829;
      13: return 16'h100D;
      14: return 16'h2015;
      15: return 16'h6000;
      16: return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  localparam logic [15:0] TAPS16 = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS = TAPS16[WIDTH-1:0];

  function automatic logic [WIDTH-1:0] lfsr_step(
    input logic [WIDTH-1:0] s
  );
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH*DIMENSION-1:0] data_q, wt_q;
  logic mode_q;
  logic [WIDTH-1:0] rng_d, rng_w;
  logic [DIMENSION-1:0] sd, sw, prod;
  logic [SEL_W-1:0] sel;
  logic add_q;
  logic [CW-1:0] run_cnt, acc, acc_nxt;
  logic last, filled;

  assign last = run_cnt == CW'(N + 1);
  assign filled = run_cnt >= CW'(2);
  assign acc_nxt = acc + CW'(add_q);
  assign prod = mode_q ? ~(sd ^ sw) : (sd & sw);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      wt_q    <= '0;
      mode_q  <= 1'b0;
      rng_d   <= SEED_DATA;
      rng_w   <= SEED_WEIGHT;
      sd      <= '0;
      sw      <= '0;
      sel     <= '0;
      add_q   <= 1'b0;
      run_cnt <= '0;
      acc     <= '0;
      count   <= '0;
      dot     <= '0;
    end else begin
      case (state)
        LOAD: begin
          data_q  <= data;
          wt_q    <= weights;
          mode_q  <= mode;
          rng_d   <= SEED_DATA;
          rng_w   <= SEED_WEIGHT;
          sd      <= '0;
          sw      <= '0;
          sel     <= '0;
          add_q   <= 1'b0;
          run_cnt <= '0;
          acc     <= '0;
        end
        RUN: begin
          rng_d <= lfsr_step(rng_d);
          rng_w <= lfsr_step(rng_w);
          for (int d = 0; d < DIMENSION; d++) begin
            sd[d] <= data_q[d*WIDTH +: WIDTH] > rng_d;
            sw[d] <= wt_q[d*WIDTH +: WIDTH] > rng_w;
          end
          sel     <= sel + 1'b1;
          add_q   <= prod[sel];
          run_cnt <= run_cnt + 1'b1;
          // first two RUN edges only fill the SNG and adder registers
          if (filled) acc <= acc_nxt;
          if (last) begin
            count <= acc_nxt;
            dot   <= DW'(acc_nxt) << SHIFT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_dot_product_engine.sv
// Bench for sc_dot_product_engine: table vectors, random runs
// against a stream-level model, plus start/reset corner cases.
module tb_sc_dot_product_engine;

  localparam int D = 4;
  localparam int N = 256;

  logic clk = 1'b0;
  logic rst, start, mode;
  logic [31:0] data, weights;
  logic busy, done;
  logic [8:0] count;
  logic [18:0] dot;

  sc_dot_product_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .data(data), .weights(weights),
    .busy(busy), .done(done), .count(count), .dot(dot)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act,
                         input longint lo, input longint hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d",
               nm, act, lo, hi);
    end
  endtask

  // random sources: x^8+x^6+x^5+x^4 maximal sequences from the seeds
  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // sample j of the adder stream takes channel (j+1) mod D
  function automatic int model(input logic m, input logic [31:0] d,
                               input logic [31:0] w);
    logic [7:0] rd, rw;
    logic a, b;
    int c, ch;
    rd = 8'hC3;
    rw = 8'h81;
    c = 0;
    for (int j = 0; j < N; j++) begin
      ch = (j + 1) % D;
      a = d[ch*8 +: 8] > rd;
      b = w[ch*8 +: 8] > rw;
      c += m ? int'(a == b) : int'(a & b);
      rd = nxt(rd);
      rw = nxt(rw);
    end
    return c;
  endfunction

  task automatic run(input logic m, input logic [31:0] d,
                     input logic [31:0] w, input int hold,
                     input bit poke, output int lat, output int nd,
                     output bit bok, output int cnt,
                     output longint dt, output bit stab);
    bit seen;
    int after;
    mode = m; data = d; weights = w; start = 1'b1;
    lat = -1; nd = 0; bok = 1; cnt = -1; dt = -1; stab = 1;
    seen = 0; after = 0;
    for (int i = 0; i < 2000 && after < 10; i++) begin
      @(negedge clk);
      if (i == 2) begin
        data = $urandom;
        weights = $urandom;
        mode = 1'($urandom);
      end
      if (done) begin
        nd++;
        if (!seen) begin
          seen = 1; lat = i; cnt = int'(count); dt = longint'(dot);
        end
      end
      if ((!seen || done) && i >= 1 && !busy) bok = 0;
      if (seen && !done) begin
        after++;
        if (busy) bok = 0;
        if (int'(count) != cnt || longint'(dot) != dt) stab = 0;
      end
      start = (i < hold - 1) ||
              (poke && (i == 50 || (done && nd == 1)));
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string nm, input logic m,
                           input logic [31:0] d, input logic [31:0] w,
                           input int hold, input bit poke,
                           input longint lo, input longint hi,
                           output int cnt);
    int lat, nd, exp_c;
    bit bok, stab;
    longint dt;
    exp_c = model(m, d, w);
    run(m, d, w, hold, poke, lat, nd, bok, cnt, dt, stab);
    chk({nm, " latency"}, lat, N + 3);
    chk({nm, " done_pulses"}, nd, 1);
    chk({nm, " busy"}, bok, 1);
    chk({nm, " stable"}, stab, 1);
    chk({nm, " count"}, cnt, exp_c);
    chk({nm, " dot"}, dt, longint'(exp_c) * 1024);
    chk_rng({nm, " dot_range"}, dt, lo, hi);
  endtask

  typedef struct {
    string nm;
    logic m;
    logic [31:0] d;
    logic [31:0] w;
    longint lo;
    longint hi;
  } vec_t;

  vec_t tv[5];

  initial begin
    int c, c1, c2, c_ff, nd;
    bit ok;
    logic m;
    logic [31:0] rd, rw;

    tv[0] = '{"uni_zero", 1'b0, 32'h0, 32'hFFFFFFFF, 0, 0};
    tv[1] = '{"uni_ff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
              256000, 262144};
    tv[2] = '{"uni_f0ca", 1'b0, 32'hF0F0F0F0, 32'hCACACACA,
              178406, 209433};
    tv[3] = '{"bip_zero", 1'b1, 32'h0, 32'h0, 262144, 262144};
    tv[4] = '{"bip_half", 1'b1, 32'h80808080, 32'h80808080,
              106496, 155648};

    rst = 1'b1; start = 1'b0; mode = 1'b0;
    data = '0; weights = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst count", count, 0);
    chk("rst dot", dot, 0);
    rst = 1'b0;
    ok = 1;
    repeat (20) begin
      @(negedge clk);
      if (busy || done || count != 0 || dot != 0) ok = 0;
    end
    chk("idle_hold", ok, 1);

    c_ff = -1;
    for (int k = 0; k < 5; k++) begin
      check_run(tv[k].nm, tv[k].m, tv[k].d, tv[k].w, 1, 0,
                tv[k].lo, tv[k].hi, c);
      if (k == 1) c_ff = c;
    end

    for (int k = 0; k < 6; k++) begin
      m = 1'($urandom);
      rd = $urandom;
      rw = $urandom;
      check_run("random", m, rd, rw, 1, 0, 0, 262144, c);
    end

    check_run("poke", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1,
              256000, 262144, c1);
    check_run("b2b", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0,
              256000, 262144, c2);
    chk("b2b repeat", c2, c1);
    check_run("held", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 0,
              256000, 262144, c);

    mode = 1'b0; data = '1; weights = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst count", count, 0);
    chk("midrst dot", dot, 0);
    nd = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) nd++;
    end
    rst = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("midrst no_done", nd, 0);
    check_run("after_rst", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0,
              256000, 262144, c);
    chk("after_rst same", c, c_ff);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
